// File: rtl/arp_pkg.sv
// ARP-over-Ethernet/IPv4 constants and helpers shared by the encoder and the
// receive-side decoder.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN         = 8'd6;
  localparam logic [7:0]  ARP_PLEN         = 8'd4;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;
  localparam int          ARP_LEN          = 28;
  localparam int          ARP_IDX_W        = 5;
  localparam int          ARP_BITS         = ARP_LEN * 8;

  localparam logic [ARP_IDX_W-1:0] ARP_LAST_IDX = ARP_IDX_W'(ARP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } arp_state_t;

  typedef struct packed {
    logic        request;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_fields_t;

  function automatic logic [15:0] arp_oper(input logic request);
    return request ? ARP_OPER_REQUEST : ARP_OPER_REPLY;
  endfunction

  // Whole packet in wire order, byte 0 in the top bits.
  function automatic logic [ARP_BITS-1:0] arp_packet(input arp_fields_t f);
    return {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
            arp_oper(f.request), f.sha, f.spa, f.tha, f.tpa};
  endfunction

  // Out-of-range indices are clamped to the last byte so the part-select
  // below can never reach outside the packet vector.
  function automatic logic [7:0] arp_byte(input arp_fields_t f,
                                          input logic [ARP_IDX_W-1:0] idx);
    logic [ARP_BITS-1:0]  p;
    logic [ARP_IDX_W-1:0] i;
    int                   lsb;
    p   = arp_packet(f);
    i   = (idx > ARP_LAST_IDX) ? ARP_LAST_IDX : idx;
    lsb = 8 * (ARP_LEN - 1 - int'(i));
    return p[lsb +: 8];
  endfunction

endpackage

// File: rtl/arp_encode.sv
// Serialises one 28-byte ARP packet per start onto a valid/ready byte stream.
// Fields are captured at start so upstream may change them mid-packet.
module arp_encode
  import arp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        request,
  input  logic [47:0] sha,
  input  logic [31:0] spa,
  input  logic [47:0] tha,
  input  logic [31:0] tpa,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done
);

  arp_state_t           state, state_n;
  arp_fields_t          fields, fields_n;
  logic [ARP_IDX_W-1:0] idx, idx_n;
  logic [7:0]           dout_n;
  logic                 vld_n;
  logic                 xfer;

  assign xfer = dout_valid && dout_ready;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    state_n  = state;
    fields_n = fields;
    idx_n    = idx;
    dout_n   = dout;
    vld_n    = dout_valid;
    case (state)
      ST_IDLE: begin
        vld_n  = 1'b0;
        dout_n = 8'h00;
        if (start) begin
          fields_n.request = request;
          fields_n.sha     = sha;
          fields_n.spa     = spa;
          fields_n.tha     = tha;
          fields_n.tpa     = tpa;
          idx_n            = '0;
          state_n          = ST_SEND;
          vld_n            = 1'b1;
          // Byte 0 is loaded straight from the freshly captured fields.
          dout_n           = arp_byte(fields_n, '0);
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (idx == ARP_LAST_IDX) begin
            state_n = ST_DONE;
            vld_n   = 1'b0;
            dout_n  = 8'h00;
          end else begin
            idx_n  = idx + 1'b1;
            dout_n = arp_byte(fields, idx_n);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        vld_n   = 1'b0;
        dout_n  = 8'h00;
      end
      default: begin
        state_n = ST_IDLE;
        vld_n   = 1'b0;
        dout_n  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fields     <= '0;
      idx        <= '0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      fields     <= fields_n;
      idx        <= idx_n;
      dout       <= dout_n;
      dout_valid <= vld_n;
    end
  end

endmodule

// File: doc/arp_encode.md
ARP_ENCODE -- requirements
Module: arp_encode

Interface
REQ-001 Parameters: none; all field widths fixed by the ARP/Ethernet/IPv4 format.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  single-cycle request to emit one 28-byte ARP packet.
REQ-006 request  in  1  sampled with start: 1 = OPER 1 (request), 0 = OPER 2 (reply).
REQ-007 sha  in  48  sender MAC (local), sampled with start.
REQ-008 spa  in  32  sender IPv4 (local), sampled with start.
REQ-009 tha  in  48  target MAC, sampled with start.
REQ-010 tpa  in  32  target IPv4, sampled with start.
REQ-011 dout  out  8  current packet byte.
REQ-012 dout_valid  out  1  dout holds a valid byte.
REQ-013 dout_ready  in  1  downstream accepts dout this cycle.
REQ-014 busy  out  1  packet in progress; start ignored.
REQ-015 done  out  1  one-cycle pulse after final byte accepted.

Function
REQ-016 Byte order SHALL be network order, MSB first per field: HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04, OPER (2 B), SHA (6), SPA (4), THA (6), TPA (4); 28 bytes total, indices 0..27.
REQ-017 States SHALL be IDLE, SEND, DONE.
REQ-018 IDLE: start=1 latches sha/spa/tha/tpa/request into internal registers, clears byte index to 0, next state SEND.
REQ-019 SEND: dout_valid=1, dout = byte[index]; index increments only in a cycle with dout_valid && dout_ready (handshake).
REQ-020 dout and dout_valid SHALL be registered; first byte valid the cycle after start is sampled (latency 1).
REQ-021 dout SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-022 Accepting byte 27 SHALL move to DONE; dout_valid deasserts the next cycle.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; back-to-back start accepted in the IDLE cycle after DONE.
REQ-024 busy SHALL be 1 in SEND and DONE, 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored; latched fields unchanged.
REQ-026 Input field changes after start SHALL NOT affect the packet in progress.
REQ-027 Byte index SHALL be 5 bits, never exceeding 27; no wrap-around emission.
REQ-028 dout SHALL be 8'h00 when dout_valid=0.

Reset
REQ-029 rst SHALL force IDLE, index 0, dout 0, dout_valid 0, busy 0, done 0, latched fields 0.
REQ-030 rst mid-packet SHALL abort immediately; no further bytes, no done pulse.
REQ-031 rst has priority over simultaneous start.

Structure
REQ-032 Package arp_pkg SHALL hold: ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'd6, ARP_PLEN=8'd4, ARP_OPER_REQUEST=16'd1, ARP_OPER_REPLY=16'd2, ARP_LEN=28, state enum type.
REQ-033 Constants SHALL be shared with the ARP receive-side decoder via arp_pkg.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Reply, dout_ready=1: sha=02:00:00:00:00:01, spa=192.168.1.10, tha=AA:BB:CC:DD:EE:FF, tpa=192.168.1.20, request=0 -> 28 consecutive bytes 00 01 08 00 06 04 00 02 02 00 00 00 00 01 C0 A8 01 0A AA BB CC DD EE FF C0 A8 01 14, then done pulse.
REQ-036 Backpressure: dout_ready toggled 1/0 per cycle -> same 28 bytes, each held stable while stalled, 56+ cycles, single done.
REQ-037 Request mode: request=1 -> bytes 6..7 = 00 01; all other bytes as in REQ-035.
REQ-038 start during byte 10 with different sha -> ignored; packet unchanged, busy stays 1.
REQ-039 rst asserted at byte 15 -> dout_valid 0 next cycle, no done; new start after reset emits full packet from byte 0.
REQ-040 Loopback: arp_encode output fed to the ARP decoder -> decoded sha/spa/tha/tpa match inputs, decoder err=0 for request=1.
